mem_responder: RTL and testbench

- Memory-side responder for the 8-bit core's req/ready memory handshake.
- Owns a single 2^ADDR_W x DATA_W synchronous RAM and serves two initiators:
  - port A: instruction fetch.
  - port B: execute-stage load/store.
- Fixed priority to port B, programmable wait states, four-phase handshake.
- Sits between the core's fetch/execute units and storage.

---
 rtl/mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the 8-bit core's req/ready handshake. Owns one
//   2^ADDR_W x DATA_W synchronous RAM shared by two initiators: port A
//   (instruction fetch, read-only) and port B (execute-stage load/store).
//   Port B has fixed priority. Each transaction spends WAIT_CYCLES extra cycles
//   between grant and access. The granted port's ready stays high until that
//   port drops its request (four-phase handshake).
//
//   Optional feature macro: MEM_WP_EN
//     When defined, port-B writes to addresses >= WP_BASE are dropped.
//     o_wp_err pulses for the access cycle of each dropped write.
//     When undefined, every address is writable and o_wp_err is constant 0.
//
//   Ports
//     i_clk       clock, all logic on the rising edge
//     i_rst       synchronous active-high reset
//     i_a_req     port A request, held until o_a_ready is seen
//     i_a_we      port A write enable (fetch is read-only, so it is ignored)
//     i_a_addr    port A address
//     o_a_rdata   port A read data, held until the next port A read completes
//     o_a_ready   port A completion
//     i_b_req     port B request
//     i_b_we      port B write enable (1 = store)
//     i_b_addr    port B address
//     i_b_wdata   port B store data
//     o_b_rdata   port B read data, held until the next port B read completes
//     o_b_ready   port B completion
//     o_wp_err    one-cycle pulse on a blocked write
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
`ifdef MEM_WP_EN
  ,
  parameter logic [ADDR_W-1:0] WP_BASE = ADDR_W'(8'hF0)
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic              o_a_ready,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_b_ready,
  output logic              o_wp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_cnt;
  logic                r_grantB;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_aRdata;
  logic [DATA_W-1:0]   r_bRdata;
  logic                r_wpErr;
  logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic                w_access;
  logic                w_grantedReq;
  logic                w_wpBlock;
  logic                w_unusedAWe;

  // Fetch never writes, so the port A write enable goes nowhere.
  assign w_unusedAWe  = i_a_we;

  assign w_access     = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_grantedReq = r_grantB ? i_b_req : i_a_req;

  // r_we is only ever set by a port B grant, so this only blocks stores.
`ifdef MEM_WP_EN
  assign w_wpBlock = r_we && (r_addr >= WP_BASE);
`else
  assign w_wpBlock = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DONE waits for the granted request to drop. This
  // forces at least one IDLE cycle between transactions.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (i_b_req || i_a_req) w_nextState = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0)      w_nextState = S_DONE;
      S_DONE:  if (!w_grantedReq)      w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Grant latching, wait counting and read-data capture.
  // Requester inputs are sampled only at grant. Later changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= 4'd0;
      r_grantB <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_aRdata <= '0;
      r_bRdata <= '0;
      r_wpErr  <= 1'b0;
    end else begin
      r_wpErr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_b_req) begin
            r_grantB <= 1'b1;
            r_we     <= i_b_we;
            r_addr   <= i_b_addr;
            r_wdata  <= i_b_wdata;
            r_cnt    <= CNT_INIT;
          end else if (i_a_req) begin
            r_grantB <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= i_a_addr;
            r_cnt    <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_we) begin
            if (r_grantB) r_bRdata <= r_mem[r_addr];
            else          r_aRdata <= r_mem[r_addr];
          end else begin
            r_wpErr <= w_wpBlock;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port. The RAM is never cleared. A reset on the access edge
  // suppresses the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_access && r_we && !w_wpBlock) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Outputs. Ready is high exactly while in DONE for the granted port.
  always_comb begin
    o_a_ready = (r_state == S_DONE) && !r_grantB;
    o_b_ready = (r_state == S_DONE) &&  r_grantB;
    o_a_rdata = r_aRdata;
    o_b_rdata = r_bRdata;
    o_wp_err  = r_wpErr;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Self-checking bench for mem_responder. It uses three instances, with
//   WAIT_CYCLES = 1, 0 and 3.
//   Expected values come from a transaction-level model:
//     - a memory array with valid bits;
//     - the last read value per port;
//     - latency computed as 1 + WAIT_CYCLES edges after the grant edge.
module tb_mem_responder;

  localparam int NDUT = 3;
  localparam int WC [NDUT] = '{1, 0, 3};

  logic       clk;
  logic       rst    [NDUT];
  logic       aReq   [NDUT];
  logic       aWe    [NDUT];
  logic [7:0] aAddr  [NDUT];
  logic [7:0] aRdata [NDUT];
  logic       aReady [NDUT];
  logic       bReq   [NDUT];
  logic       bWe    [NDUT];
  logic [7:0] bAddr  [NDUT];
  logic [7:0] bWdata [NDUT];
  logic [7:0] bRdata [NDUT];
  logic       bReady [NDUT];
  logic       wpErr  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    mem_responder #(
      .ADDR_W      (8),
      .DATA_W      (8),
      .WAIT_CYCLES (WC[g])
    ) u_dut (
      .i_clk     (clk),
      .i_rst     (rst[g]),
      .i_a_req   (aReq[g]),
      .i_a_we    (aWe[g]),
      .i_a_addr  (aAddr[g]),
      .o_a_rdata (aRdata[g]),
      .o_a_ready (aReady[g]),
      .i_b_req   (bReq[g]),
      .i_b_we    (bWe[g]),
      .i_b_addr  (bAddr[g]),
      .i_b_wdata (bWdata[g]),
      .o_b_rdata (bRdata[g]),
      .o_b_ready (bReady[g]),
      .o_wp_err  (wpErr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] model   [NDUT][256];
  bit         valid   [NDUT][256];
  logic [7:0] expA    [NDUT];
  logic [7:0] expB    [NDUT];
  logic [7:0] validQ  [$];

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    bit         portB;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         hold;
    bit         dropEarly;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run one complete transaction on instance d and check it against the model.
  task automatic applyStimulus(input int d, input bit portB, input bit we,
                               input logic [7:0] addr, input logic [7:0] wdata,
                               input int hold, input bit dropEarly);
    int  lat;
    int  wpCount;
    bit  otherSeen;
    bit  heldOk;
    bit  blocked;
    bit  isWrite;
    bit  rdy;
    isWrite   = portB && we;
    blocked   = 1'b0;
`ifdef MEM_WP_EN
    blocked   = isWrite && (addr >= 8'hF0);
`endif
    wpCount   = 0;
    otherSeen = 1'b0;
    heldOk    = 1'b1;
    if (portB) begin
      bReq[d] = 1'b1; bWe[d] = we; bAddr[d] = addr; bWdata[d] = wdata;
    end else begin
      aReq[d] = 1'b1; aWe[d] = 1'($urandom_range(0, 1)); aAddr[d] = addr;
    end
    tick();
    // Inputs changed after the grant edge must have no effect.
    if (portB) begin
      bWe[d] = 1'($urandom_range(0, 1)); bAddr[d] = 8'($urandom); bWdata[d] = 8'($urandom);
      if (dropEarly) bReq[d] = 1'b0;
    end else begin
      aWe[d] = 1'($urandom_range(0, 1)); aAddr[d] = 8'($urandom);
      if (dropEarly) aReq[d] = 1'b0;
    end
    lat = 0;
    do begin
      tick();
      lat++;
      if (wpErr[d]) wpCount++;
      if (portB ? aReady[d] : bReady[d]) otherSeen = 1'b1;
      rdy = portB ? bReady[d] : aReady[d];
    end while (!rdy && lat < 40);
    checkOutput("latency", lat, 1 + WC[d]);
    if (!isWrite) begin
      if (portB) expB[d] = model[d][addr];
      else       expA[d] = model[d][addr];
    end
    if (!dropEarly) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        if (wpErr[d]) wpCount++;
        if (portB ? aReady[d] : bReady[d]) otherSeen = 1'b1;
        if (!(portB ? bReady[d] : aReady[d])) heldOk = 1'b0;
      end
      if (portB) bReq[d] = 1'b0; else aReq[d] = 1'b0;
    end
    tick();
    if (wpErr[d]) wpCount++;
    checkOutput("ready release", portB ? bReady[d] : aReady[d], 0);
    if (hold > 0 && !dropEarly) checkOutput("ready held", heldOk, 1);
    checkOutput("wp pulses", wpCount, blocked ? 1 : 0);
    checkOutput("other ready", otherSeen, 0);
    if (isWrite && !blocked) begin
      model[d][addr] = wdata;
      valid[d][addr] = 1'b1;
      if (d == 0) validQ.push_back(addr);
    end
    checkOutput("a_rdata", aRdata[d], expA[d]);
    checkOutput("b_rdata", bRdata[d], expB[d]);
  endtask

  initial begin
    int lat;
    bit overlap;
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; aReq[d] = 1'b0; aWe[d] = 1'b0; aAddr[d] = 8'h00;
      bReq[d] = 1'b0; bWe[d] = 1'b0; bAddr[d] = 8'h00; bWdata[d] = 8'h00;
      expA[d] = 8'h00; expB[d] = 8'h00;
      for (int i = 0; i < 256; i++) begin model[d][i] = 8'h00; valid[d][i] = 1'b0; end
    end
    tick();
    tick();
    for (int d = 0; d < NDUT; d++) begin
      checkOutput("reset a_ready", aReady[d], 0);
      checkOutput("reset b_ready", bReady[d], 0);
      checkOutput("reset wp_err",  wpErr[d],  0);
      checkOutput("reset a_rdata", aRdata[d], 0);
      checkOutput("reset b_rdata", bRdata[d], 0);
      rst[d] = 1'b0;
    end
    tick();

    // Directed table on the WAIT_CYCLES=1 instance
    vecs[0]  = '{1'b1, 1'b1, 8'h10, 8'h5A, 0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'h5A};
    vecs[2]  = '{1'b1, 1'b1, 8'h40, 8'h77, 0, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h40, 8'h00, 1, 1'b0, 8'h77};
    vecs[4]  = '{1'b0, 1'b0, 8'h40, 8'h00, 2, 1'b0, 8'h77};
    vecs[5]  = '{1'b1, 1'b1, 8'hF4, 8'h00, 0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 8'hF4, 8'hFF, 0, 1'b0, 8'h00};
`ifdef MEM_WP_EN
    vecs[7]  = '{1'b1, 1'b0, 8'hF4, 8'h00, 0, 1'b0, 8'h00};
`else
    vecs[7]  = '{1'b1, 1'b0, 8'hF4, 8'h00, 0, 1'b0, 8'hFF};
`endif
    vecs[8]  = '{1'b1, 1'b1, 8'hEF, 8'h3C, 0, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 8'hEF, 8'h00, 0, 1'b0, 8'h3C};
    vecs[10] = '{1'b0, 1'b0, 8'hEF, 8'h00, 0, 1'b0, 8'h3C};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, vecs[i].portB, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].hold, vecs[i].dropEarly);
      if (!(vecs[i].portB && vecs[i].we))
        checkOutput("table rdata", vecs[i].portB ? bRdata[0] : aRdata[0], vecs[i].expRdata);
    end

    // Simultaneous requests: B write 33 to 10 wins, then A reads 10
    aReq[0] = 1'b1; aWe[0] = 1'b0; aAddr[0] = 8'h10;
    bReq[0] = 1'b1; bWe[0] = 1'b1; bAddr[0] = 8'h10; bWdata[0] = 8'h33;
    overlap = 1'b0;
    tick();
    lat = 0;
    do begin
      tick(); lat++;
      if (aReady[0]) overlap = 1'b1;
    end while (!bReady[0] && lat < 40);
    checkOutput("prio b latency", lat, 1 + WC[0]);
    bReq[0] = 1'b0;
    tick();
    checkOutput("prio b release", bReady[0], 0);
    model[0][8'h10] = 8'h33;
    lat = 0;
    do begin
      tick(); lat++;
      if (bReady[0]) overlap = 1'b1;
    end while (!aReady[0] && lat < 40);
    checkOutput("prio a latency", lat, 2 + WC[0]);
    expA[0] = model[0][8'h10];
    checkOutput("prio a_rdata", aRdata[0], expA[0]);
    aReq[0] = 1'b0;
    tick();
    checkOutput("prio a release", aReady[0], 0);
    checkOutput("prio overlap", overlap, 0);

    // Latency at WAIT_CYCLES = 0 and 3 with ready held for 5 extra cycles
    for (int d = 1; d < NDUT; d++) begin
      applyStimulus(d, 1'b1, 1'b1, 8'h20, 8'hC3, 0, 1'b0);
      applyStimulus(d, 1'b0, 1'b0, 8'h20, 8'h00, 5, 1'b0);
      applyStimulus(d, 1'b1, 1'b0, 8'h20, 8'h00, 5, 1'b0);
      applyStimulus(d, 1'b1, 1'b1, 8'h21, 8'h9E, 0, 1'b1);
      applyStimulus(d, 1'b0, 1'b0, 8'h21, 8'h00, 0, 1'b0);
    end

    // Reset during the wait phase of a write must abort it
    applyStimulus(0, 1'b1, 1'b1, 8'h50, 8'h11, 0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    bReq[0] = 1'b1; bWe[0] = 1'b1; bAddr[0] = 8'h50; bWdata[0] = 8'hAA;
    tick();
    rst[0] = 1'b1;
    tick();
    bReq[0] = 1'b0;
    tick();
    rst[0] = 1'b0;
    expA[0] = 8'h00;
    expB[0] = 8'h00;
    checkOutput("abort b_ready", bReady[0], 0);
    checkOutput("abort a_ready", aReady[0], 0);
    checkOutput("abort wp_err",  wpErr[0],  0);
    checkOutput("abort b_rdata", bRdata[0], expB[0]);
    checkOutput("abort a_rdata", aRdata[0], expA[0]);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 8'h50, 8'h00, 0, 1'b0);
    checkOutput("abort keeps ram", bRdata[0], 8'h11);

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      bit         pB;
      bit         w;
      logic [7:0] ad;
      pB = 1'($urandom_range(0, 1));
      w  = pB && ($urandom_range(0, 1) == 1);
      if (w) ad = 8'($urandom);
      else   ad = validQ[$urandom_range(0, validQ.size() - 1)];
      applyStimulus(0, pB, w, ad, 8'($urandom), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
